// File: rtl/jesd207_ensm_responder_pkg.sv
// Shared definitions for the JESD207 ENSM responder and the BBP-side FIFO wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jesd207_ensm_responder_pkg;

    // Bus word width default, shared with the BBP-side FIFO wrapper.
    localparam int JESD207_DW_DEFAULT = 12;

    // Guard countdown width; holds GUARD_CYCLES-1 for GUARD_CYCLES in 1..15.
    localparam int GUARD_W = 4;

    // ENSM state encodings. 5..7 are illegal and fall back to ALERT.
    typedef enum logic [2:0] {
        ST_ALERT = 3'd0,
        ST_GUARD = 3'd1,
        ST_RX    = 3'd2,
        ST_TX    = 3'd3,
        ST_FLUSH = 3'd4
    } ensm_state_t;

    // Active state entered when the guard interval expires.
    function automatic ensm_state_t active_state(input logic mode_tx);
        return mode_tx ? ST_TX : ST_RX;
    endfunction

endpackage

// File: rtl/jesd207_ensm_responder_if.sv
// Bundles the ENABLE/TXNRX controls, the RX sample source, the RX/TX data buses and the TX sample sink.
// Latency: n/a (wiring only).
// Backpressure: src_ready is the only backpressure; the sink and both buses have none.
// Ports: master = BBP/local-source side (drives controls, source and TX bus); slave = responder.
interface jesd207_ensm_responder_if
    import jesd207_ensm_responder_pkg::*;
#(
    parameter int DW = JESD207_DW_DEFAULT
) ();

    logic          enable;
    logic          tx_nrx;
    logic          src_valid;
    logic [DW-1:0] src_i;
    logic [DW-1:0] src_q;
    logic          src_ready;
    logic          rx_frame;
    logic [DW-1:0] rx_data;
    logic          tx_frame;
    logic [DW-1:0] tx_data;
    logic          snk_valid;
    logic [DW-1:0] snk_i;
    logic [DW-1:0] snk_q;

    modport master (
        output enable, tx_nrx, src_valid, src_i, src_q, tx_frame, tx_data,
        input  src_ready, rx_frame, rx_data, snk_valid, snk_i, snk_q
    );

    modport slave (
        input  enable, tx_nrx, src_valid, src_i, src_q, tx_frame, tx_data,
        output src_ready, rx_frame, rx_data, snk_valid, snk_i, snk_q
    );

endinterface

// File: rtl/jesd207_pulse_detect.sv
// Rising-edge detector for the ENABLE pulse input; a level held high yields a single event.
// Latency: pulse is combinational from sig against a 1-cycle registered copy.
// Backpressure: none.
// Ports: fclk/rstn clock and async active-low reset; sig input level; pulse output event.
module jesd207_pulse_detect (
    input  logic fclk,
    input  logic rstn,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/jesd207_ensm_responder.sv
// RF-IC-side JESD207 responder: ENSM state machine, RX I/Q serialiser and TX I/Q de-framer.
// Latency: RX handshake -> I word on rx_data 1 cycle, Q word the cycle after; TX Q word -> snk pair 1 cycle.
// Backpressure: src_ready throttles the RX source (one pair every 2 cycles); TX sink has none.
// Ports: fclk, rstn; bus (slave modport: enable, tx_nrx, src_*, rx_*, tx_*, snk_*);
//        state_o, frame_err, sample_cnt, underrun_cnt status outputs.
module jesd207_ensm_responder
    import jesd207_ensm_responder_pkg::*;
#(
    parameter int DW           = JESD207_DW_DEFAULT,
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                     fclk,
    input  logic                     rstn,
    jesd207_ensm_responder_if.slave  bus,
    output logic [2:0]               state_o,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         underrun_cnt
);

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ensm_state_t        state,        state_nxt;
    logic               mode_tx,      mode_tx_nxt;
    logic [GUARD_W-1:0] guard_cnt,    guard_cnt_nxt;
    logic               phase,        phase_nxt;
    logic               have_i,       have_i_nxt;
    logic [DW-1:0]      q_hold,       q_hold_nxt;
    logic [DW-1:0]      i_hold,       i_hold_nxt;
    logic               rx_frame_r,   rx_frame_nxt;
    logic [DW-1:0]      rx_data_r,    rx_data_nxt;
    logic               snk_valid_r,  snk_valid_nxt;
    logic [DW-1:0]      snk_i_r,      snk_i_nxt;
    logic [DW-1:0]      snk_q_r,      snk_q_nxt;
    logic               frame_err_r,  frame_err_nxt;
    logic [CNT_W-1:0]   sample_cnt_r, sample_cnt_nxt;
    logic [CNT_W-1:0]   underrun_r,   underrun_nxt;

    logic pulse;
    logic flush_req;
    logic src_ready_c;

    jesd207_pulse_detect u_pulse_detect (
        .fclk  (fclk),
        .rstn  (rstn),
        .sig   (bus.enable),
        .pulse (pulse)
    );

    // A pulse while active is a stop request; it must gate src_ready in
    // the same cycle so no pair is accepted that could not be sent.
    assign flush_req   = pulse & ((state == ST_RX) | (state == ST_TX));
    assign src_ready_c = (state == ST_RX) & ~phase & ~flush_req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_ALERT;
            mode_tx      <= 1'b0;
            guard_cnt    <= '0;
            phase        <= 1'b0;
            have_i       <= 1'b0;
            q_hold       <= '0;
            i_hold       <= '0;
            rx_frame_r   <= 1'b0;
            rx_data_r    <= '0;
            snk_valid_r  <= 1'b0;
            snk_i_r      <= '0;
            snk_q_r      <= '0;
            frame_err_r  <= 1'b0;
            sample_cnt_r <= '0;
            underrun_r   <= '0;
        end else begin
            state        <= state_nxt;
            mode_tx      <= mode_tx_nxt;
            guard_cnt    <= guard_cnt_nxt;
            phase        <= phase_nxt;
            have_i       <= have_i_nxt;
            q_hold       <= q_hold_nxt;
            i_hold       <= i_hold_nxt;
            rx_frame_r   <= rx_frame_nxt;
            rx_data_r    <= rx_data_nxt;
            snk_valid_r  <= snk_valid_nxt;
            snk_i_r      <= snk_i_nxt;
            snk_q_r      <= snk_q_nxt;
            frame_err_r  <= frame_err_nxt;
            sample_cnt_r <= sample_cnt_nxt;
            underrun_r   <= underrun_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        mode_tx_nxt    = mode_tx;
        guard_cnt_nxt  = guard_cnt;
        phase_nxt      = phase;
        have_i_nxt     = have_i;
        q_hold_nxt     = q_hold;
        i_hold_nxt     = i_hold;
        // The RX bus idles at zero and snk_valid is a single-cycle strobe,
        // so these default low every cycle rather than holding.
        rx_frame_nxt   = 1'b0;
        rx_data_nxt    = '0;
        snk_valid_nxt  = 1'b0;
        snk_i_nxt      = snk_i_r;
        snk_q_nxt      = snk_q_r;
        frame_err_nxt  = frame_err_r;
        sample_cnt_nxt = sample_cnt_r;
        underrun_nxt   = underrun_r;

        case (state)
            ST_ALERT: begin
                if (pulse) begin
                    mode_tx_nxt    = bus.tx_nrx;
                    guard_cnt_nxt  = GUARD_INIT;
                    sample_cnt_nxt = '0;
                    underrun_nxt   = '0;
                    frame_err_nxt  = 1'b0;
                    phase_nxt      = 1'b0;
                    have_i_nxt     = 1'b0;
                    state_nxt      = ST_GUARD;
                end
            end

            ST_GUARD: begin
                // Pulses are deliberately ignored until the guard expires.
                if (guard_cnt == '0) begin
                    state_nxt = active_state(mode_tx);
                end else begin
                    guard_cnt_nxt = guard_cnt - GUARD_W'(1);
                end
            end

            ST_RX: begin
                if (phase) begin
                    // Q of an accepted pair always goes out, even on a stop.
                    rx_data_nxt = q_hold;
                    phase_nxt   = 1'b0;
                    if (flush_req) begin
                        state_nxt = ST_FLUSH;
                    end
                end else if (flush_req) begin
                    state_nxt = ST_FLUSH;
                end else if (bus.src_valid) begin
                    rx_frame_nxt   = 1'b1;
                    rx_data_nxt    = bus.src_i;
                    q_hold_nxt     = bus.src_q;
                    phase_nxt      = 1'b1;
                    sample_cnt_nxt = sample_cnt_r + CNT_W'(1);
                end else if (underrun_r != '1) begin
                    underrun_nxt = underrun_r + CNT_W'(1);
                end
            end

            ST_TX: begin
                if (flush_req) begin
                    // Half-received pair is dropped silently on stop.
                    have_i_nxt = 1'b0;
                    state_nxt  = ST_FLUSH;
                end else if (bus.tx_frame) begin
                    if (have_i) begin
                        frame_err_nxt = 1'b1;
                    end
                    i_hold_nxt = bus.tx_data;
                    have_i_nxt = 1'b1;
                end else if (have_i) begin
                    snk_i_nxt      = i_hold;
                    snk_q_nxt      = bus.tx_data;
                    snk_valid_nxt  = 1'b1;
                    have_i_nxt     = 1'b0;
                    sample_cnt_nxt = sample_cnt_r + CNT_W'(1);
                end
            end

            ST_FLUSH: begin
                phase_nxt  = 1'b0;
                have_i_nxt = 1'b0;
                state_nxt  = ST_ALERT;
            end

            default: begin
                state_nxt = ST_ALERT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.src_ready = src_ready_c;
    assign bus.rx_frame  = rx_frame_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.snk_valid = snk_valid_r;
    assign bus.snk_i     = snk_i_r;
    assign bus.snk_q     = snk_q_r;

    assign state_o      = state;
    assign frame_err    = frame_err_r;
    assign sample_cnt   = sample_cnt_r;
    assign underrun_cnt = underrun_r;

endmodule

// File: doc/jesd207_ensm_responder.md
Name: jesd207_ensm_responder

Overview:
- RF-IC-side responder for the JESD207 control/data interface, the far end from the FIFO controller that drives jesd_en/tx_nrx.
- Decodes ENABLE pulses and TXNRX into an ENSM-style state machine.
- In RX mode, serialises I/Q sample pairs from a local source onto rx_frame/rx_data.
- In TX mode, de-frames tx_frame/tx_data into I/Q pairs for a local sink.

Parameters:
- DW, 12, data bus width per I or Q word.
- GUARD_CYCLES, 2, fclk cycles between an accepted start pulse and an active state; legal range 1..15.
- CNT_W, 16, width of the sample and underrun counters.

Ports:
- fclk  input  1  interface clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- enable  input  1  ENABLE from BBP; pulse mode, rising edge = event.
- tx_nrx  input  1  TXNRX from BBP; 1 = BBP transmits (responder captures), 0 = responder sends.
- src_valid  input  1  RX source has a sample.
- src_i  input  DW  RX I word.
- src_q  input  DW  RX Q word.
- src_ready  output  1  combinational; = (state==RX) & (phase==0) & ~flush_req.
- rx_frame  output  1  registered; high on I word.
- rx_data  output  DW  registered RX bus word.
- tx_frame  input  1  TX frame marker; high on I word.
- tx_data  input  DW  TX bus word.
- snk_valid  output  1  one-cycle pulse, pair valid.
- snk_i  output  DW  captured I.
- snk_q  output  DW  captured Q.
- state_o  output  3  current state encoding.
- frame_err  output  1  sticky TX framing error.
- sample_cnt  output  CNT_W  samples moved in current burst; wraps.
- underrun_cnt  output  CNT_W  RX idle slots; saturates at all-ones.

Behaviour:
- Reset values: all outputs and registers 0; state ALERT (3'd0).
- Edge detect:
  - en_q <= enable.
  - pulse = enable & ~en_q.
  - An enable held high counts once.
- States: ALERT=0, GUARD=1, RX=2, TX=3, FLUSH=4. Encodings 5–7 return to ALERT on the next cycle.
- ALERT:
  - pulse -> mode_tx <= tx_nrx; guard counter <= GUARD_CYCLES-1; clear sample_cnt, underrun_cnt, frame_err, phase, have_i; go to GUARD.
- GUARD:
  - Count down; at 0 go to TX if mode_tx, else RX.
  - Pulses during GUARD are ignored.
- RX, phase 0:
  - src_valid (handshake) -> rx_frame<=1, rx_data<=src_i, q_hold<=src_q, phase<=1, sample_cnt++.
  - No src_valid -> rx_frame<=0, rx_data<=0, underrun_cnt++ (saturating).
- RX, phase 1:
  - rx_frame<=0, rx_data<=q_hold, phase<=0.
  - Latency is 1 cycle from handshake to I on the bus; Q always follows on the next cycle.
- TX:
  - tx_frame=1 and have_i=0 -> i_hold<=tx_data, have_i<=1.
  - tx_frame=0 and have_i=1 -> snk_i<=i_hold, snk_q<=tx_data, snk_valid<=1, have_i<=0, sample_cnt++.
  - tx_frame=0 and have_i=0 -> idle word, ignored.
  - tx_frame=1 and have_i=1 -> frame_err<=1 (sticky); new word replaces i_hold.
  - snk_valid is 1 cycle and has no backpressure.
- Stop pulse in RX or TX -> FLUSH, with these rules:
  - RX at phase 1: the Q word is still emitted in the FLUSH cycle.
  - RX: no new handshake is accepted once the stop pulse is seen (src_ready low).
  - TX: a pending have_i is discarded without error.
  - FLUSH lasts 1 cycle -> ALERT, with rx_frame/rx_data driven to 0.
- Reset mid-burst: immediate return to the reset values, with no partial sample emitted.
- Counter rules: sample_cnt wraps modulo 2^CNT_W; sample_cnt and underrun_cnt hold in ALERT until the next start pulse.

Decomposition:
- Shared package holds: state encodings; a DW default constant shared with the FIFO wrapper.
- Natural sub-module: jesd207_pulse_detect (registered rising-edge detector on enable, reused by the BBP-side controller).

Test Plan:
1. Reset; enable pulse with tx_nrx=0, GUARD_CYCLES=2 -> GUARD for 2 cycles, then RX; src pairs (0x123,0x456),(0x789,0xABC) back-to-back -> rx_data 123,456,789,ABC; rx_frame 1,0,1,0; sample_cnt=2.
2. RX with src_valid low for 3 slots -> rx_frame=0, rx_data=0 in those slots; underrun_cnt=3.
3. Pulse with tx_nrx=1 -> TX; bus (f=1,0x0AA),(0,0x055) -> snk_valid one cycle, snk_i=0x0AA, snk_q=0x055; frame_err=0.
4. TX sequence f=1,f=1,f=0 -> frame_err=1; pair emitted uses the second I word.
5. Stop pulse during RX phase 1 -> Q word still output, then FLUSH, then ALERT; src_ready low from the pulse cycle onward.
6. Enable held high for 5 cycles in ALERT -> exactly one transition; rstn low mid-TX burst -> state 0, snk_valid 0 asynchronously.
